// File: rtl/apb_master.sv
// APB3 requester: accepts single-beat commands on a valid/ready port and issues
// one APB3 transfer per command, returning data/error on a one-cycle response strobe.
module apb_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A 1-bit counter is kept when the timeout is disabled so widths stay legal.
    localparam bit              TIMEOUT_EN  = (TIMEOUT > 0);
    localparam int              CNT_W       = TIMEOUT_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    timeout_hit;
    logic                    cmd_ready_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;

    // Saturating wait-state count as it would be after the current ACCESS cycle.
    always_comb begin
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit = TIMEOUT_EN && (cnt_d == TIMEOUT_CNT);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_wdata;
                        pwrite_q    <= cmd_write;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so a completion on the limit cycle is not aborted.
                    if (PREADY) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                    end else if (timeout_hit) begin
                        cnt_q         <= cnt_d;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction-level completer/reference model
// predicts latency and response fields for each command from the protocol rules.
module tb_apb_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_xfer   = 0;
    logic [31:0] mem [4];
    logic [31:0] hold_rdata;
    logic        hold_err;
    logic        hold_to;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the master is idle.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            PREADY    = 1'($urandom);
            PSLVERR   = 1'($urandom);
            PRDATA    = $urandom;
            @(negedge PCLK);
            check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("idle_ready", 32'(cmd_ready), 32'd1);
            check_eq("idle_psel", 32'(PSEL), 32'd0);
            check_eq("hold_rdata", rsp_rdata, hold_rdata);
            check_eq("hold_err", 32'(rsp_err), 32'(hold_err));
            check_eq("hold_timeout", 32'(rsp_timeout), 32'(hold_to));
        end
        PREADY = 1'b0;
    endtask

    // One command; 'waits' = ACCESS cycles with PREADY low before PREADY goes high.
    task automatic run_xfer(input logic wr, input logic [1:0] idx, input logic [31:0] wd,
                            input int waits, input logic err);
        logic [AW-1:0] addr;
        logic          exp_to;
        logic          exp_err;
        logic [31:0]   exp_rd;
        int            exp_lat;
        int            t;
        bit            done;
        addr    = {1'b0, idx, 2'b00};
        exp_to  = (waits >= TO);
        exp_lat = exp_to ? 2 + TO : 3 + waits;
        exp_err = exp_to | err;
        exp_rd  = (!wr && !exp_to) ? mem[idx] : 32'h0;

        check_eq("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        PREADY    = 1'($urandom);
        PSLVERR   = 1'($urandom);
        PRDATA    = $urandom;
        t    = 0;
        done = 0;
        while (!done && t < 20) begin
            @(negedge PCLK);
            t++;
            if (rsp_valid) begin
                done = 1;
                check_eq("latency", 32'(t), 32'(exp_lat));
                check_eq("rsp_rdata", rsp_rdata, exp_rd);
                check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
                check_eq("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
                check_eq("rsp_psel", 32'(PSEL), 32'd0);
                check_eq("rsp_penable", 32'(PENABLE), 32'd0);
                check_eq("rsp_ready", 32'(cmd_ready), 32'd1);
                cmd_valid = 1'b0;
                PREADY    = 1'b0;
            end else begin
                check_eq("busy_psel", 32'(PSEL), 32'd1);
                check_eq("busy_penable", 32'(PENABLE), (t >= 2) ? 32'd1 : 32'd0);
                check_eq("busy_ready", 32'(cmd_ready), 32'd0);
                check_eq("busy_paddr", 32'(PADDR), 32'(addr));
                check_eq("busy_pwrite", 32'(PWRITE), 32'(wr));
                check_eq("busy_pwdata", PWDATA, wd);
                // Stray commands while busy must not be consumed or disturb the bus.
                cmd_valid = 1'($urandom);
                cmd_write = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = $urandom;
                if (t >= 2 && (t - 2) == waits) begin
                    PREADY  = 1'b1;
                    PSLVERR = err;
                    PRDATA  = mem[idx];
                end else begin
                    PREADY  = (t >= 2) ? 1'b0 : 1'($urandom);
                    PSLVERR = 1'($urandom);
                    PRDATA  = $urandom;
                end
            end
        end
        if (!done) begin
            check_eq("rsp_within_bound", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            PREADY    = 1'b0;
        end
        if (wr && !exp_to && !err) mem[idx] = wd;
        hold_rdata = exp_rd;
        hold_err   = exp_err;
        hold_to    = exp_to;
        n_xfer++;
        $display("xfer %0d: %s addr=%h wdata=%h waits=%0d slverr=%0d -> lat=%0d rdata=%h err=%0d timeout=%0d",
                 n_xfer, wr ? "WR" : "RD", addr, wd, waits, err, t, rsp_rdata, rsp_err, rsp_timeout);
    endtask

    task automatic back_to_back();
        logic [1:0] ra [4];
        int         k;
        for (int i = 0; i < 4; i++) ra[i] = 2'($urandom);
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) @(negedge PCLK);
            k = (t / 3 > 3) ? 3 : t / 3;
            check_eq("b2b_ready", 32'(cmd_ready), (t % 3 == 0) ? 32'd1 : 32'd0);
            check_eq("b2b_rsp_valid", 32'(rsp_valid), (t > 0 && t % 3 == 0) ? 32'd1 : 32'd0);
            check_eq("b2b_psel", 32'(PSEL), (t % 3 != 0) ? 32'd1 : 32'd0);
            if (t > 0 && t % 3 == 0) begin
                check_eq("b2b_rdata", rsp_rdata, mem[ra[t/3-1]]);
                check_eq("b2b_err", 32'(rsp_err), 32'd0);
                n_xfer++;
                $display("xfer %0d: RD back-to-back idx=%0d rdata=%h at cycle %0d",
                         n_xfer, ra[t/3-1], rsp_rdata, t);
            end
            cmd_valid = (t < 12);
            cmd_write = 1'b0;
            cmd_addr  = {1'b0, ra[k], 2'b00};
            cmd_wdata = $urandom;
            PREADY    = 1'b1;
            PSLVERR   = 1'b0;
            PRDATA    = mem[ra[k]];
        end
        PREADY     = 1'b0;
        cmd_valid  = 1'b0;
        hold_rdata = mem[ra[3]];
        hold_err   = 1'b0;
        hold_to    = 1'b0;
    endtask

    task automatic reset_mid_access();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'h08;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            PREADY    = 1'b0;
            check_eq("rst_pre_psel", 32'(PSEL), 32'd1);
        end
        check_eq("rst_pre_penable", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        check_eq("rst_psel", 32'(PSEL), 32'd0);
        check_eq("rst_penable", 32'(PENABLE), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        hold_rdata = 32'h0;
        hold_err   = 1'b0;
        hold_to    = 1'b0;
        n_xfer++;
        $display("xfer %0d: RD aborted by reset during ACCESS", n_xfer);
    endtask

    initial begin
        mem[0] = 32'hA5A5_0000;
        mem[1] = 32'h0BAD_F00D;
        mem[2] = 32'h1234_5678;
        mem[3] = 32'hCAFE_0003;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("reset_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_psel", 32'(PSEL), 32'd0);
        check_eq("reset_penable", 32'(PENABLE), 32'd0);
        check_eq("reset_pwrite", 32'(PWRITE), 32'd0);
        check_eq("reset_paddr", 32'(PADDR), 32'd0);
        check_eq("reset_pwdata", PWDATA, 32'd0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        PRESET     = 1'b0;
        hold_rdata = 32'h0;
        hold_err   = 1'b0;
        hold_to    = 1'b0;
        idle_cycles(1);

        run_xfer(1'b1, 2'd1, 32'hDEAD_BEEF, 0, 1'b0);
        run_xfer(1'b0, 2'd2, $urandom, 3, 1'b0);
        run_xfer(1'b1, 2'd3, 32'h5555_AAAA, 1, 1'b1);
        run_xfer(1'b0, 2'd3, $urandom, 0, 1'b0);
        idle_cycles(2);
        run_xfer(1'b0, 2'd0, $urandom, TO, 1'b0);
        run_xfer(1'b0, 2'd0, $urandom, TO - 1, 1'b0);
        run_xfer(1'b1, 2'd1, $urandom, TO + 2, 1'b1);
        run_xfer(1'b0, 2'd1, $urandom, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_xfer(1'($urandom), 2'($urandom), $urandom,
                     int'($urandom_range(0, TO + 1)), ($urandom_range(0, 3) == 0));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        back_to_back();
        idle_cycles(1);
        reset_mid_access();
        idle_cycles(2);
        run_xfer(1'b0, 2'd2, $urandom, 1, 1'b0);
        idle_cycles(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
